hazard_ctrl: RTL and testbench

- Hazard and pipeline-sequencing controller for the 5-stage core.
- Drives the stall (hold) and flush (clear) controls of the F/D, D/E, E/M and M/W pipeline registers, and the E-stage forwarding selects.
- Contains a memory-wait FSM with a watchdog timeout, plus saturating stall and flush performance counters.

---
 rtl/hazard_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
// Hazard and sequencing controller for the 5-stage core. It produces:
//   - the E-stage forwarding selects;
//   - hold/clear controls for the F/D, D/E, E/M and M/W pipeline registers;
//   - a memory-wait FSM with a watchdog that latches a sticky error;
//   - saturating stall and flush performance counters.
//
// Ports
//   clk, rst                 clock (rising edge), async active-high reset
//   Rs1D, Rs2D               source registers of the instruction in D
//   Rs1E, Rs2E, RdE          source and destination registers in E
//   RdM, RdW                 destination registers in M and W
//   RegWriteM, RegWriteW     register write enables in M and W
//   ResultSrcE0              the instruction in E is a load
//   PCSrcE                   a taken branch/jump is resolved in E
//   MemAccessM               a load/store is in M
//   mem_ready                data memory completes the access this cycle
//   cnt_clr                  synchronous clear of both counters
//   ForwardAE, ForwardBE     00 regfile, 01 W result, 10 M ALU result
//   StallF/D/E/M             hold the PC / pipeline register (1 = hold)
//   FlushD/E/W               clear the pipeline register
//   mem_err                  sticky watchdog error
//   stall_cnt, flush_cnt     saturating performance counters
// ---------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             ResultSrcE0,
  input  logic             PCSrcE,
  input  logic             MemAccessM,
  input  logic             mem_ready,
  input  logic             cnt_clr,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // The timer must hold TIMEOUT-1 and is never narrower than 7 bits.
  localparam int unsigned TMR_BITS = $clog2(TIMEOUT + 1);
  localparam int unsigned TMR_W    = (TMR_BITS > 7) ? TMR_BITS : 7;

  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic lw_stall;
  logic mem_stall;

  // Forwarding select for one E-stage source; M result is newer than W.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic       we_m,
    input logic [4:0] rd_m,
    input logic       we_w,
    input logic [4:0] rd_w
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (we_m && (rd_m != 5'd0) && (rd_m == rs)) begin
      sel = 2'b10;
    end else if (we_w && (rd_w != 5'd0) && (rd_w == rs)) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  // Forwarding selects
  always_comb begin
    ForwardAE = fwd_sel(Rs1E, RegWriteM, RdM, RegWriteW, RdW);
    ForwardBE = fwd_sel(Rs2E, RegWriteM, RdM, RegWriteW, RdW);
  end

  // Load-use hazard between E and D
  always_comb begin
    lw_stall = ResultSrcE0 && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  // FSM next state: miss enters WAIT, ready or withdrawn access returns to RUN
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    unique case (state_q)
      ST_RUN: begin
        if (MemAccessM && !mem_ready) begin
          state_d = ST_WAIT;
          timer_d = TMR_ONE;
        end
      end
      ST_WAIT: begin
        if (mem_ready || !MemAccessM) begin
          state_d = ST_RUN;
          timer_d = '0;
        end else if (timer_q == TMR_LAST) begin
          state_d = ST_ERR;
        end else begin
          timer_d = timer_q + TMR_ONE;
        end
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
      default: begin
        state_d = ST_RUN;
        timer_d = '0;
      end
    endcase
  end

  // FSM outputs and pipeline controls; a memory stall freezes F..M and
  // bubbles W, so a branch resolving in E waits until the release.
  always_comb begin
    mem_err   = (state_q == ST_ERR);
    mem_stall = mem_err || (MemAccessM && !mem_ready);
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;
    if (mem_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else begin
      StallF = lw_stall && !PCSrcE;
      StallD = lw_stall;
      FlushD = PCSrcE;
      FlushE = lw_stall || PCSrcE;
    end
  end

  // Saturating counters; clear wins over increment
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (cnt_clr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (StallF && (stall_cnt_q != CNT_MAX)) stall_cnt_d = stall_cnt_q + CNT_ONE;
      if (FlushD && (flush_cnt_q != CNT_MAX)) flush_cnt_d = flush_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
// Directed-vector bench for hazard_ctrl with TIMEOUT=4 and CNT_W=4 so the
// watchdog and counter saturation are reachable in a few cycles.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

  localparam int unsigned TIMEOUT = 4;
  localparam int unsigned CNT_W   = 4;

  logic             clk;
  logic             rst;
  logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic             RegWriteM, RegWriteW, ResultSrcE0, PCSrcE;
  logic             MemAccessM, mem_ready, cnt_clr;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             StallF, StallD, StallE, StallM;
  logic             FlushD, FlushE, FlushW;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int unsigned vec_cnt;
  int unsigned miss_cnt;

  hazard_ctrl #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .Rs1D        (Rs1D),
    .Rs2D        (Rs2D),
    .Rs1E        (Rs1E),
    .Rs2E        (Rs2E),
    .RdE         (RdE),
    .RdM         (RdM),
    .RdW         (RdW),
    .RegWriteM   (RegWriteM),
    .RegWriteW   (RegWriteW),
    .ResultSrcE0 (ResultSrcE0),
    .PCSrcE      (PCSrcE),
    .MemAccessM  (MemAccessM),
    .mem_ready   (mem_ready),
    .cnt_clr     (cnt_clr),
    .ForwardAE   (ForwardAE),
    .ForwardBE   (ForwardBE),
    .StallF      (StallF),
    .StallD      (StallD),
    .StallE      (StallE),
    .StallM      (StallM),
    .FlushD      (FlushD),
    .FlushE      (FlushE),
    .FlushW      (FlushW),
    .mem_err     (mem_err),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; inputs change 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0;
    RdE = '0; RdM = '0; RdW = '0;
    RegWriteM = 1'b0; RegWriteW = 1'b0; ResultSrcE0 = 1'b0; PCSrcE = 1'b0;
    MemAccessM = 1'b0; mem_ready = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic check_mem_stall(input string tag);
    check({tag, "_stallF"}, 32'(StallF), 32'd1);
    check({tag, "_stallD"}, 32'(StallD), 32'd1);
    check({tag, "_stallE"}, 32'(StallE), 32'd1);
    check({tag, "_stallM"}, 32'(StallM), 32'd1);
    check({tag, "_flushW"}, 32'(FlushW), 32'd1);
    check({tag, "_flushD"}, 32'(FlushD), 32'd0);
    check({tag, "_flushE"}, 32'(FlushE), 32'd0);
  endtask

  initial begin
    vec_cnt  = 0;
    miss_cnt = 0;
    rst      = 1'b1;
    clear_inputs();

    // Reset state
    #3;
    check("rst_mem_err", 32'(mem_err), 32'd0);
    check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    check("rst_flush_cnt", 32'(flush_cnt), 32'd0);
    check("rst_stallF", 32'(StallF), 32'd0);
    check("rst_fwdA", 32'(ForwardAE), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_stall_cnt", 32'(stall_cnt), 32'd0);

    // Load-use on Rs1D
    ResultSrcE0 = 1'b1; RdE = 5'd5; Rs1D = 5'd5;
    #1;
    check("lu_stallF", 32'(StallF), 32'd1);
    check("lu_stallD", 32'(StallD), 32'd1);
    check("lu_flushE", 32'(FlushE), 32'd1);
    check("lu_flushD", 32'(FlushD), 32'd0);
    check("lu_stallE", 32'(StallE), 32'd0);
    check("lu_flushW", 32'(FlushW), 32'd0);
    tick();
    check("lu_stall_cnt", 32'(stall_cnt), 32'd1);
    check("lu_flush_cnt", 32'(flush_cnt), 32'd0);

    // Load into x0 never stalls
    RdE = 5'd0; Rs1D = 5'd0;
    #1;
    check("lu_x0_stallF", 32'(StallF), 32'd0);
    check("lu_x0_flushE", 32'(FlushE), 32'd0);
    tick();
    check("lu_x0_stall_cnt", 32'(stall_cnt), 32'd1);

    // Load-use on Rs2D
    RdE = 5'd7; Rs2D = 5'd7; Rs1D = 5'd1;
    #1;
    check("lu_rs2_stallD", 32'(StallD), 32'd1);
    tick();
    check("lu_rs2_stall_cnt", 32'(stall_cnt), 32'd2);

    // Forwarding
    clear_inputs();
    RegWriteM = 1'b1; RdM = 5'd3; RegWriteW = 1'b1; RdW = 5'd3; Rs1E = 5'd3; Rs2E = 5'd0;
    #1;
    check("fwd_m_prio", 32'(ForwardAE), 32'd2);
    check("fwd_b_none", 32'(ForwardBE), 32'd0);
    RegWriteM = 1'b0;
    #1;
    check("fwd_w", 32'(ForwardAE), 32'd1);
    RegWriteM = 1'b1; RdM = 5'd0; RdW = 5'd0; Rs1E = 5'd0;
    #1;
    check("fwd_x0", 32'(ForwardAE), 32'd0);
    RdM = 5'd3; RdW = 5'd4; Rs1E = 5'd3; Rs2E = 5'd4;
    #1;
    check("fwd_a_m", 32'(ForwardAE), 32'd2);
    check("fwd_b_w", 32'(ForwardBE), 32'd1);
    RegWriteW = 1'b0;
    #1;
    check("fwd_b_nowe", 32'(ForwardBE), 32'd0);

    // Branch together with load-use
    clear_inputs();
    ResultSrcE0 = 1'b1; RdE = 5'd5; Rs1D = 5'd5; PCSrcE = 1'b1;
    #1;
    check("br_lu_stallF", 32'(StallF), 32'd0);
    check("br_lu_flushD", 32'(FlushD), 32'd1);
    check("br_lu_flushE", 32'(FlushE), 32'd1);
    tick();
    check("br_lu_flush_cnt", 32'(flush_cnt), 32'd1);
    check("br_lu_stall_cnt", 32'(stall_cnt), 32'd2);

    // Branch alone
    clear_inputs();
    PCSrcE = 1'b1;
    #1;
    check("br_flushD", 32'(FlushD), 32'd1);
    check("br_stallD", 32'(StallD), 32'd0);
    tick();
    check("br_flush_cnt", 32'(flush_cnt), 32'd2);

    // Memory wait of 3 cycles with a pending branch held frozen
    clear_inputs();
    MemAccessM = 1'b1; mem_ready = 1'b0; PCSrcE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_mem_stall($sformatf("mw%0d", i));
      tick();
    end
    mem_ready = 1'b1;
    #1;
    check("mw_rel_stallF", 32'(StallF), 32'd0);
    check("mw_rel_flushW", 32'(FlushW), 32'd0);
    check("mw_rel_flushD", 32'(FlushD), 32'd1);
    PCSrcE = 1'b0;
    tick();
    check("mw_stall_cnt", 32'(stall_cnt), 32'd5);
    check("mw_flush_cnt", 32'(flush_cnt), 32'd2);
    check("mw_mem_err", 32'(mem_err), 32'd0);

    // Access withdrawn during WAIT
    mem_ready = 1'b0;
    tick();
    MemAccessM = 1'b0;
    #1;
    check("wd_stallF", 32'(StallF), 32'd0);
    tick();
    check("wd_stall_cnt", 32'(stall_cnt), 32'd6);

    // Watchdog: ERR on the 4th stalled edge
    MemAccessM = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("wdog_pre_err", 32'(mem_err), 32'd0);
    tick();
    check("wdog_err", 32'(mem_err), 32'd1);
    check("wdog_stall_cnt", 32'(stall_cnt), 32'd10);
    MemAccessM = 1'b0; mem_ready = 1'b1;
    #1;
    check_mem_stall("err");
    tick();
    check("err_sticky", 32'(mem_err), 32'd1);
    check("err_stall_cnt", 32'(stall_cnt), 32'd11);

    // Asynchronous reset out of ERR, between edges
    #2;
    rst = 1'b1;
    #1;
    check("arst_mem_err", 32'(mem_err), 32'd0);
    check("arst_stallF", 32'(StallF), 32'd0);
    check("arst_stall_cnt", 32'(stall_cnt), 32'd0);
    check("arst_flush_cnt", 32'(flush_cnt), 32'd0);
    #1;
    rst = 1'b0;
    tick();

    // Counter saturation and clear
    clear_inputs();
    PCSrcE = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("sat_flush_pre", 32'(flush_cnt), 32'd3);
    clear_inputs();
    ResultSrcE0 = 1'b1; RdE = 5'd9; Rs2D = 5'd9;
    for (int i = 0; i < 14; i++) tick();
    check("sat_14", 32'(stall_cnt), 32'd14);
    for (int i = 0; i < 6; i++) tick();
    check("sat_15", 32'(stall_cnt), 32'd15);
    check("sat_flush_hold", 32'(flush_cnt), 32'd3);
    cnt_clr = 1'b1;
    tick();
    check("clr_stall", 32'(stall_cnt), 32'd0);
    check("clr_flush", 32'(flush_cnt), 32'd0);
    cnt_clr = 1'b0;
    tick();
    check("clr_resume", 32'(stall_cnt), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
